memtile_cfg_loader: RTL and testbench

Configuration initiator for one Lake memory tile: on `start` it walks a register table held in an external ROM and drives the tile's `config_en`/`config_write`/`config_addr_in`/`config_data_in` port as a sequence of single-cycle writes. It then pulses `flush` to arm the address and schedule generators, and reports `done`. It sits between the top-level boot sequencer and a memtile instance, for example a long-delay tile with write start 61 and range 65535, and replaces constant tie-offs on the config port.

---
 rtl/memtile_cfg_loader.sv | 171 +++++++++++++++++
 tb/tb_memtile_cfg_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/memtile_cfg_loader.sv
// Walks a ROM register table into a memtile config port, then pulses flush and reports done.
// Define MEMTILE_CFG_READBACK_EN to read back and verify every written register.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | ROM read of entry idx
// WRITE  | config write of entry idx, addr/data taken straight from the ROM
// READ   | config read of entry idx (readback build only)
// CHECK  | compare tile read data with the written data (readback build only)
// FLUSH  | flush held high for FLUSH_CYCLES cycles
// DONE   | load complete; start re-runs the sequence
module memtile_cfg_loader #(
  parameter int NUM_ENTRIES  = 24,
  parameter int IDX_W        = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rom_en,
  output logic [IDX_W-1:0] rom_idx,
  input  logic [7:0]       rom_addr,
  input  logic [31:0]      rom_data,
  output logic             config_en,
  output logic             config_write,
  output logic             config_read,
  output logic [7:0]       config_addr_in,
  output logic [31:0]      config_data_in,
  input  logic [31:0]      config_data_out,
  output logic             flush,
  output logic             cfg_err,
  output logic [IDX_W-1:0] err_idx
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((NUM_ENTRIES == 0) ? 0 : NUM_ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WRITE = 3'd2,
`ifdef MEMTILE_CFG_READBACK_EN
    S_READ  = 3'd3,
    S_CHECK = 3'd4,
`endif
    S_FLUSH = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [FC_W-1:0]   fcnt;
  logic              wr_q;
  logic              rd_q;

`ifdef MEMTILE_CFG_READBACK_EN
  logic [7:0]        addr_q;
  logic [31:0]       data_q;
  logic              err_q;
  logic [IDX_W-1:0]  err_idx_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      fcnt   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      rom_en <= 1'b0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      flush  <= 1'b0;
`ifdef MEMTILE_CFG_READBACK_EN
      addr_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
`endif
    end else begin
      rom_en <= 1'b0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      flush  <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx  <= '0;
            busy <= 1'b1;
            done <= 1'b0;
`ifdef MEMTILE_CFG_READBACK_EN
            err_q     <= 1'b0;
            err_idx_q <= '0;
`endif
            if (NUM_ENTRIES == 0) begin
              state <= S_FLUSH;
              flush <= 1'b1;
              fcnt  <= FC_W'(FLUSH_CYCLES - 1);
            end else begin
              state  <= S_FETCH;
              rom_en <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          state <= S_WRITE;
          wr_q  <= 1'b1;
        end
        S_WRITE: begin
`ifdef MEMTILE_CFG_READBACK_EN
          addr_q <= rom_addr;
          data_q <= rom_data;
          state  <= S_READ;
          rd_q   <= 1'b1;
        end
        S_READ: begin
          state <= S_CHECK;
        end
        S_CHECK: begin
          // Only the first mismatch is recorded; loading carries on regardless.
          if (config_data_out != data_q && !err_q) begin
            err_q     <= 1'b1;
            err_idx_q <= idx;
          end
`endif
          if (idx == LAST_IDX) begin
            state <= S_FLUSH;
            flush <= 1'b1;
            fcnt  <= FC_W'(FLUSH_CYCLES - 1);
          end else begin
            idx    <= idx + IDX_W'(1);
            state  <= S_FETCH;
            rom_en <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (fcnt == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            fcnt  <= fcnt - FC_W'(1);
            flush <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rom_idx        = rom_en ? idx : '0;
  assign config_en      = wr_q | rd_q;
  assign config_write   = wr_q;
  assign config_read    = rd_q;
  assign config_data_in = wr_q ? rom_data : '0;

`ifdef MEMTILE_CFG_READBACK_EN
  assign config_addr_in = wr_q ? rom_addr : (rd_q ? addr_q : '0);
  assign cfg_err        = err_q;
  assign err_idx        = err_idx_q;
`else
  logic unused_rd_data;
  assign unused_rd_data = ^config_data_out;
  assign config_addr_in = wr_q ? rom_addr : '0;
  assign cfg_err        = 1'b0;
  assign err_idx        = '0;
`endif

endmodule

// File: tb/tb_memtile_cfg_loader.sv
// Self-checking bench for memtile_cfg_loader: a 3-entry delay-tile table and an empty table.
// Builds with or without MEMTILE_CFG_READBACK_EN; per-entry cost changes with the macro.
module tb_memtile_cfg_loader;

`ifdef MEMTILE_CFG_READBACK_EN
  localparam int STEP = 4;
  localparam bit RB   = 1'b1;
`else
  localparam int STEP = 2;
  localparam bit RB   = 1'b0;
`endif
  localparam int LAT = 1 + STEP * 3 + 2;

  logic clk = 1'b0;
  logic rst, start, start_e;
  always #5 clk = ~clk;

  logic        busy, done, rom_en, config_en, config_write, config_read, flush, cfg_err;
  logic [4:0]  rom_idx, err_idx;
  logic [7:0]  rom_addr, config_addr_in;
  logic [31:0] rom_data, config_data_in, config_data_out;

  logic        e_busy, e_done, e_rom_en, e_config_en, e_config_write, e_config_read, e_flush, e_cfg_err;
  logic [4:0]  e_rom_idx, e_err_idx;
  logic [7:0]  e_config_addr_in;
  logic [31:0] e_config_data_in;

  memtile_cfg_loader #(.NUM_ENTRIES(3), .IDX_W(5), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rom_en(rom_en), .rom_idx(rom_idx), .rom_addr(rom_addr), .rom_data(rom_data),
    .config_en(config_en), .config_write(config_write), .config_read(config_read),
    .config_addr_in(config_addr_in), .config_data_in(config_data_in),
    .config_data_out(config_data_out), .flush(flush), .cfg_err(cfg_err), .err_idx(err_idx)
  );

  memtile_cfg_loader #(.NUM_ENTRIES(0), .IDX_W(5), .FLUSH_CYCLES(2)) dut_e (
    .clk(clk), .rst(rst), .start(start_e), .busy(e_busy), .done(e_done),
    .rom_en(e_rom_en), .rom_idx(e_rom_idx), .rom_addr(8'h00), .rom_data(32'h0),
    .config_en(e_config_en), .config_write(e_config_write), .config_read(e_config_read),
    .config_addr_in(e_config_addr_in), .config_data_in(e_config_data_in),
    .config_data_out(32'h0), .flush(e_flush), .cfg_err(e_cfg_err), .err_idx(e_err_idx)
  );

  logic [7:0]  tab_addr [3] = '{8'h10, 8'h11, 8'h12};
  logic [31:0] tab_data [3] = '{32'd61, 32'd1, 32'd65535};

  // ROM with one-cycle read latency
  always @(posedge clk) begin
    if (rom_en && rom_idx < 5'd3) begin
      rom_addr <= tab_addr[rom_idx];
      rom_data <= tab_data[rom_idx];
    end
  end

  // Tile model: register 0x10 reads back wrong (60) to provoke a readback mismatch
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (config_en && config_write) mem[config_addr_in] <= config_data_in;
    if (config_en && config_read)
      config_data_out <= (config_addr_in == 8'h10) ? 32'd60 : mem[config_addr_in];
  end

  int wr_count = 0;
  int viol = 0;
  always @(posedge clk) if (!rst && config_en && config_write) wr_count <= wr_count + 1;
  always @(negedge clk) begin
    if ((config_en && flush) || (config_write && config_read) || e_config_en)
      viol <= viol + 1;
  end

  typedef struct {
    logic        start;
    logic        busy, done, rom_en;
    logic [4:0]  rom_idx;
    logic        en, wr, rd, flush, err;
    logic [4:0]  eidx;
    logic [7:0]  addr;
    logic [31:0] data;
  } vec_t;

  function automatic logic [63:0] pk(vec_t v);
    return 64'({v.busy, v.done, v.rom_en, v.rom_idx, v.en, v.wr, v.rd, v.flush,
                v.err, v.eidx, v.addr, v.data});
  endfunction

  logic [63:0] obs;
  assign obs = 64'({busy, done, rom_en, rom_idx, config_en, config_write, config_read, flush,
                    cfg_err, err_idx, config_addr_in, config_data_in});

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      cyc();
      n++;
    end
    check("done_reached", 64'(done), 64'd1);
  endtask

  vec_t vecs [$];

  initial begin
    vec_t v;
    int w0;

    // Vector table for the delay-tile load: entry k fetched at 1+STEP*k, written at 2+STEP*k
    for (int c = 1; c <= LAT + 1; c++) begin
      v = '{default: '0};
      v.start = (c == 1);
      v.busy  = (c < LAT);
      v.done  = (c >= LAT);
      for (int k = 0; k < 3; k++) begin
        if (c == 1 + STEP * k) begin v.rom_en = 1'b1; v.rom_idx = 5'(k); end
        if (c == 2 + STEP * k) begin
          v.en = 1'b1; v.wr = 1'b1; v.addr = tab_addr[k]; v.data = tab_data[k];
        end
        if (RB && c == 3 + STEP * k) begin v.en = 1'b1; v.rd = 1'b1; v.addr = tab_addr[k]; end
      end
      v.flush = (c == LAT - 2) || (c == LAT - 1);
      v.err   = RB && (c >= 5);
      vecs.push_back(v);
    end

    rst = 1'b0; start = 1'b0; start_e = 1'b0;
    #12 rst = 1'b1;
    #6  rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("idle_outputs", obs, 64'd0);
    end
    check("idle_empty_inst", 64'({e_busy, e_done, e_flush, e_config_en}), 64'd0);

    foreach (vecs[i]) begin
      start = vecs[i].start;
      cyc();
      check($sformatf("load_cycle%0d", i + 1), obs, pk(vecs[i]));
    end
    start = 1'b0;

    // Re-run from DONE clears the error state
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("rerun_clears_err", 64'({busy, done, cfg_err, err_idx}), 64'({1'b1, 1'b0, 1'b0, 5'd0}));
    wait_done(100);

    // Abort during entry 1's write
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (1 + STEP) cyc();
    check("abort_pre_write", 64'({config_en, config_write, config_addr_in}), 64'({2'b11, 8'h11}));
    rst = 1'b1;
    #1;
    check("abort_async_zero", obs, 64'd0);
    w0 = wr_count;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (12) cyc();
    check("abort_no_more_writes", 64'(wr_count - w0), 64'd0);
    check("abort_idle", 64'({busy, done}), 64'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    check("restart_idx0", 64'({config_en, config_addr_in, config_data_in}), 64'({1'b1, 8'h10, 32'd61}));
    wait_done(100);

    // start held high: one full sequence, then a re-run accepted out of DONE
    w0 = wr_count;
    start = 1'b1;
    repeat (LAT) cyc();
    check("held_done", 64'({busy, done}), 64'({1'b0, 1'b1}));
    check("held_writes", 64'(wr_count - w0), 64'd3);
    cyc();
    check("held_rerun", 64'({busy, done}), 64'({1'b1, 1'b0}));
    start = 1'b0;
    wait_done(100);
    check("held_total_writes", 64'(wr_count - w0), 64'd6);
    check("held_err_state", 64'({cfg_err, err_idx}), RB ? 64'({1'b1, 5'd0}) : 64'd0);

    // Empty table: straight to two flush cycles, done 3 cycles after start
    start_e = 1'b1;
    cyc();
    start_e = 1'b0;
    check("empty_c1", 64'({e_busy, e_flush, e_done}), 64'b110);
    cyc();
    check("empty_c2", 64'({e_busy, e_flush, e_done}), 64'b110);
    cyc();
    check("empty_c3", 64'({e_busy, e_flush, e_done}), 64'b001);

    check("protocol_violations", 64'(viol), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
